cpu_ctrl: RTL and testbench
===========================

Name: cpu_ctrl

Overview:
- Fetch/decode/sequencing stage directly upstream of the CPU datapath (register file, data memory, ALU, accumulator, flag register).
- Holds the program counter and reads one instruction per cycle from asynchronous-read program memory.
- Drives every datapath control and operand input. Consumes the datapath's registered Z flag for conditional jumps.
- Adds a small call/return stack and a RUN/HALT/FAULT state machine.

Parameters:
- WIDTH, 8, datapath word width; imm and d_mem_addr width.
- IWIDTH, 4, ALU function code width.
- PC_W, 8, program counter / program memory address width.
- INSTR_W, 20, instruction word width; fixed by the field layout below.
- REG_F_SEL_SIZE, 4, register-file select width.
- STACK_DEPTH, 4, call-stack entries; power of two, minimum 2.

Ports:
- clk  input  1  system clock, rising edge
- pc_rst_n  input  1  asynchronous active-low reset
- pmem_addr  output  PC_W  program memory address; equals PC
- pmem_data  input  INSTR_W  instruction at pmem_addr, same cycle
- start  input  1  one-cycle pulse; resumes from HALT
- flag_z_in  input  1  registered Z flag from the datapath
- reg_f_sel  output  REG_F_SEL_SIZE  register-file select
- en_reg_f  output  1  register-file write enable
- d_mem_addr  output  WIDTH  direct data-memory address
- d_mem_addr_mode  output  1  0 = address from operand, 1 = address from register
- en_d_mem  output  1  data-memory write enable
- in_b_sel  output  2  ALU B source: 00 imm, 01 reg, 1x mem
- imm  output  WIDTH  immediate operand
- alu_op  output  IWIDTH  ALU function code
- en_acc  output  1  accumulator load enable
- halted  output  1  state == HALT
- fault  output  1  state == FAULT

Behaviour:
Instruction fields:
- cls = [19:18], sub = [17:16], fn = [15:12], rs = [11:8], opnd = [7:0].
- imm, d_mem_addr and jump target are always opnd. reg_f_sel is always rs. alu_op is always fn.

Decode:
- cls 00, ALU: en_acc = 1; in_b_sel = sub, except sub 11, which gives in_b_sel = 10 and d_mem_addr_mode = 1.
- cls 01, STORE:
  - sub 00: en_reg_f = 1.
  - sub 01: en_d_mem = 1, mode 0.
  - sub 10: en_d_mem = 1, mode 1.
  - sub 11: NOP.
- cls 10, FLOW:
  - sub 00 JMP: unconditional.
  - sub 01 JZ: taken if flag_z_in = 1.
  - sub 10 JNZ: taken if flag_z_in = 0.
  - sub 11 CALL: push PC+1, then jump.
- cls 11, SYS: sub 00 RET (pop into PC); sub 01 HALT; sub 10 and sub 11 NOP.

Gating and PC update:
- All enables (en_acc, en_reg_f, en_d_mem) are 0 in every state other than RUN, and while pc_rst_n = 0.
- The remaining control outputs follow decode and are don't-care when enables are 0.
- PC next value:
  - taken jump or CALL: opnd;
  - RET: top of stack;
  - otherwise: PC+1, wrapping modulo 2^PC_W (all ones -> 0).
- Zero-latency control: outputs are combinational from pmem_data in the same cycle, and the datapath commits on the same edge that advances PC.

State machine:
- RUN -> HALT on a HALT instruction; PC holds at the HALT address.
- HALT -> RUN on start; PC <= PC+1. start in RUN or FAULT is ignored.
- FAULT is left only by reset.

Call stack:
- sp counts 0..STACK_DEPTH. CALL writes stack[sp] and increments; RET decrements and reads.

Reset (asynchronous, pc_rst_n low): PC = 0, sp = 0, state = RUN, halted = 0, fault = 0; stack contents are don't-care.

Boundaries:
- Jump to the current PC re-executes it (legal spin loop).
- JZ uses the flag value present in that cycle, i.e. the value registered by the previous ALU instruction.
- Reset asserted mid-cycle clears all state immediately.
- Reserved encodings act as NOP.

Optional Feature:
- Macro CPU_CTRL_STACK_CHK_EN.
- Defined:
  - CALL with sp = STACK_DEPTH, or RET with sp = 0, enters FAULT.
  - PC and sp are not updated, and the faulting instruction's enables are suppressed.
- Undefined:
  - no FAULT state; fault is tied 0;
  - sp wraps modulo STACK_DEPTH; an overflow overwrites the oldest entry; an underflowed RET returns stale data.

Decomposition:
- Shared package cpu_pkg holds:
  - class codes CLS_ALU, CLS_STORE, CLS_FLOW, CLS_SYS;
  - sub-op constants;
  - in_b_sel encodings;
  - field bit positions;
  - state encoding RUN/HALT/FAULT.
- One sub-module, cpu_call_stack: push/pop, sp, full/empty flags, parameterised by PC_W and STACK_DEPTH.

Test Plan:
- Reset then ALU-imm (cls 00, sub 00, fn 3, opnd 0x2A) at PC 0 -> en_acc = 1, in_b_sel = 00, imm = 0x2A, alu_op = 3; next cycle PC = 1.
- JZ to 0x10 with flag_z_in = 1 -> PC = 0x10; repeat with flag_z_in = 0 -> PC = PC+1. JNZ gives the mirrored result.
- CALL 0x40 at PC 5, then RET at 0x40 -> PC goes 5, 0x40, 6.
- Nested CALL depth 4 succeeds; 5th CALL -> fault = 1 and PC frozen with the macro; without it the 5th RET returns the overwritten entry.
- HALT at PC 0x20 -> halted = 1 and all enables 0 for 10 cycles; start pulse -> PC = 0x21, halted = 0.
- PC at 0xFF executing NOP -> PC = 0x00. Assert pc_rst_n low mid-cycle during RUN -> PC = 0 and enables 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the cpu_ctrl fetch/decode stage: instruction field
// positions, class/sub-op codes, ALU B-source selects and sequencer states.
package cpu_pkg;

  localparam int unsigned CLS_LO  = 18;
  localparam int unsigned SUB_LO  = 16;
  localparam int unsigned FN_LO   = 12;
  localparam int unsigned RS_LO   = 8;
  localparam int unsigned OPND_LO = 0;

  localparam logic [1:0] CLS_ALU   = 2'b00;
  localparam logic [1:0] CLS_STORE = 2'b01;
  localparam logic [1:0] CLS_FLOW  = 2'b10;
  localparam logic [1:0] CLS_SYS   = 2'b11;

  localparam logic [1:0] ALU_MEM_IND = 2'b11;

  localparam logic [1:0] ST_REG     = 2'b00;
  localparam logic [1:0] ST_MEM_DIR = 2'b01;
  localparam logic [1:0] ST_MEM_IND = 2'b10;

  localparam logic [1:0] FL_JMP  = 2'b00;
  localparam logic [1:0] FL_JZ   = 2'b01;
  localparam logic [1:0] FL_JNZ  = 2'b10;
  localparam logic [1:0] FL_CALL = 2'b11;

  localparam logic [1:0] SYS_RET  = 2'b00;
  localparam logic [1:0] SYS_HALT = 2'b01;

  localparam logic [1:0] BSEL_IMM = 2'b00;
  localparam logic [1:0] BSEL_REG = 2'b01;
  localparam logic [1:0] BSEL_MEM = 2'b10;

  localparam logic [1:0] S_RUN   = 2'b00;
  localparam logic [1:0] S_HALT  = 2'b01;
  localparam logic [1:0] S_FAULT = 2'b10;

endpackage

// File: rtl/cpu_call_stack.sv
// Return-address stack for CALL/RET. With CPU_CTRL_STACK_CHK_EN defined,
// overflow/underflow is reported on o_err and the access is dropped.
module cpu_call_stack
  import cpu_pkg::*;
#(
  parameter int PC_W        = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic [PC_W-1:0] i_data,
  output logic [PC_W-1:0] o_top,
  output logic            o_err
);

  localparam int AW = $clog2(STACK_DEPTH);
`ifdef CPU_CTRL_STACK_CHK_EN
  localparam int SPW = AW + 1;
`else
  // Pointer is exactly one index wide so it wraps modulo STACK_DEPTH.
  localparam int SPW = AW;
`endif

  logic [PC_W-1:0] r_mem [STACK_DEPTH];
  logic [SPW-1:0]  r_sp;
  logic [AW-1:0]   w_idx;
  logic [AW-1:0]   w_idx_dec;
  logic            w_push;
  logic            w_pop;

  assign w_idx     = r_sp[AW-1:0];
  assign w_idx_dec = w_idx - 1'b1;
  assign o_top     = r_mem[w_idx_dec];

`ifdef CPU_CTRL_STACK_CHK_EN
  logic w_full;
  logic w_empty;
  assign w_full  = (r_sp == SPW'(STACK_DEPTH));
  assign w_empty = (r_sp == '0);
  assign o_err   = (i_push & w_full) | (i_pop & w_empty);
`else
  assign o_err = 1'b0;
`endif

  assign w_push = i_push & ~o_err;
  assign w_pop  = i_pop & ~o_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sp <= '0;
    end else if (w_push) begin
      r_sp <= r_sp + 1'b1;
    end else if (w_pop) begin
      r_sp <= r_sp - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[w_idx] <= i_data;
    end
  end

endmodule

// File: rtl/cpu_ctrl.sv
// Fetch/decode/sequencing stage: PC, combinational decode, RUN/HALT/FAULT.
// Optional stack overflow/underflow fault via CPU_CTRL_STACK_CHK_EN.
module cpu_ctrl
  import cpu_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int IWIDTH         = 4,
  parameter int PC_W           = 8,
  parameter int INSTR_W        = 20,
  parameter int REG_F_SEL_SIZE = 4,
  parameter int STACK_DEPTH    = 4
) (
  input  logic                      clk,
  input  logic                      pc_rst_n,
  output logic [PC_W-1:0]           pmem_addr,
  input  logic [INSTR_W-1:0]        pmem_data,
  input  logic                      start,
  input  logic                      flag_z_in,
  output logic [REG_F_SEL_SIZE-1:0] reg_f_sel,
  output logic                      en_reg_f,
  output logic [WIDTH-1:0]          d_mem_addr,
  output logic                      d_mem_addr_mode,
  output logic                      en_d_mem,
  output logic [1:0]                in_b_sel,
  output logic [WIDTH-1:0]          imm,
  output logic [IWIDTH-1:0]         alu_op,
  output logic                      en_acc,
  output logic                      halted,
  output logic                      fault
);

  logic [PC_W-1:0] r_pc;
  logic [1:0]      r_state;
  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_target;
  logic [PC_W-1:0] w_stk_top;
  logic [1:0]      w_cls;
  logic [1:0]      w_sub;
  logic            w_run;
  logic            w_is_call;
  logic            w_is_ret;
  logic            w_is_halt;
  logic            w_taken;
  logic            w_stk_err;
  logic            w_commit;
  logic            w_acc_d;
  logic            w_regf_d;
  logic            w_dmem_d;

  assign w_cls     = pmem_data[CLS_LO +: 2];
  assign w_sub     = pmem_data[SUB_LO +: 2];
  assign w_target  = pmem_data[OPND_LO +: PC_W];
  assign imm       = pmem_data[OPND_LO +: WIDTH];
  assign d_mem_addr = pmem_data[OPND_LO +: WIDTH];
  assign alu_op    = pmem_data[FN_LO +: IWIDTH];
  assign reg_f_sel = pmem_data[RS_LO +: REG_F_SEL_SIZE];
  assign pmem_addr = r_pc;
  assign w_pc_inc  = r_pc + 1'b1;

  assign w_run     = (r_state == S_RUN);
  assign w_is_call = (w_cls == CLS_FLOW) && (w_sub == FL_CALL);
  assign w_is_ret  = (w_cls == CLS_SYS) && (w_sub == SYS_RET);
  assign w_is_halt = (w_cls == CLS_SYS) && (w_sub == SYS_HALT);

  always_comb begin
    w_acc_d         = 1'b0;
    w_regf_d        = 1'b0;
    w_dmem_d        = 1'b0;
    w_taken         = 1'b0;
    d_mem_addr_mode = 1'b0;
    in_b_sel        = BSEL_IMM;
    case (w_cls)
      CLS_ALU: begin
        w_acc_d = 1'b1;
        if (w_sub == ALU_MEM_IND) begin
          in_b_sel        = BSEL_MEM;
          d_mem_addr_mode = 1'b1;
        end else begin
          in_b_sel = w_sub;
        end
      end
      CLS_STORE: begin
        case (w_sub)
          ST_REG:     w_regf_d = 1'b1;
          ST_MEM_DIR: w_dmem_d = 1'b1;
          ST_MEM_IND: begin
            w_dmem_d        = 1'b1;
            d_mem_addr_mode = 1'b1;
          end
          default: ;
        endcase
      end
      CLS_FLOW: begin
        case (w_sub)
          FL_JZ:   w_taken = flag_z_in;
          FL_JNZ:  w_taken = ~flag_z_in;
          default: w_taken = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

  // Enables are gated by reset directly because the reset state is RUN.
  assign w_commit = w_run & pc_rst_n & ~w_stk_err;
  assign en_acc   = w_commit & w_acc_d;
  assign en_reg_f = w_commit & w_regf_d;
  assign en_d_mem = w_commit & w_dmem_d;

  cpu_call_stack #(
    .PC_W        (PC_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk    (clk),
    .rst_n  (pc_rst_n),
    .i_push (w_run & w_is_call),
    .i_pop  (w_run & w_is_ret),
    .i_data (w_pc_inc),
    .o_top  (w_stk_top),
    .o_err  (w_stk_err)
  );

  always_ff @(posedge clk or negedge pc_rst_n) begin
    if (!pc_rst_n) begin
      r_pc    <= '0;
      r_state <= S_RUN;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_stk_err)      r_state <= S_FAULT;
          else if (w_is_halt) r_state <= S_HALT;
          else if (w_is_ret)  r_pc    <= w_stk_top;
          else if (w_taken)   r_pc    <= w_target;
          else                r_pc    <= w_pc_inc;
        end
        S_HALT: begin
          if (start) begin
            r_pc    <= w_pc_inc;
            r_state <= S_RUN;
          end
        end
        default: ;
      endcase
    end
  end

  assign halted = (r_state == S_HALT);
`ifdef CPU_CTRL_STACK_CHK_EN
  assign fault = (r_state == S_FAULT);
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed plus randomized bench for cpu_ctrl against an instruction-level model.
module tb_cpu_ctrl;

  logic        clk = 1'b0;
  logic        pc_rst_n = 1'b1;
  logic [7:0]  pmem_addr;
  logic [19:0] pmem_data = '0;
  logic        start = 1'b0;
  logic        flag_z_in = 1'b0;
  logic [3:0]  reg_f_sel;
  logic        en_reg_f;
  logic [7:0]  d_mem_addr;
  logic        d_mem_addr_mode;
  logic        en_d_mem;
  logic [1:0]  in_b_sel;
  logic [7:0]  imm;
  logic [3:0]  alu_op;
  logic        en_acc;
  logic        halted;
  logic        fault;

  always #5 clk = ~clk;

  cpu_ctrl dut (
    .clk             (clk),
    .pc_rst_n        (pc_rst_n),
    .pmem_addr       (pmem_addr),
    .pmem_data       (pmem_data),
    .start           (start),
    .flag_z_in       (flag_z_in),
    .reg_f_sel       (reg_f_sel),
    .en_reg_f        (en_reg_f),
    .d_mem_addr      (d_mem_addr),
    .d_mem_addr_mode (d_mem_addr_mode),
    .en_d_mem        (en_d_mem),
    .in_b_sel        (in_b_sel),
    .imm             (imm),
    .alu_op          (alu_op),
    .en_acc          (en_acc),
    .halted          (halted),
    .fault           (fault)
  );

`ifdef CPU_CTRL_STACK_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam int M_RUN = 0, M_HALT = 1, M_FAULT = 2;

  int n_tests = 0;
  int n_fail  = 0;

  int         m_pc;
  int         m_state;
  int         m_sp;
  int         m_depth;
  logic [7:0] m_stk [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] mk(input int cls, input int sub, input int fn,
                                     input int rs, input int opnd);
    return {cls[1:0], sub[1:0], fn[3:0], rs[3:0], opnd[7:0]};
  endfunction

  task automatic model_reset();
    m_pc = 0; m_state = M_RUN; m_sp = 0; m_depth = 0;
  endtask

  // One instruction cycle: check decode mid-cycle, advance model, check PC after the edge.
  task automatic step(input logic [19:0] ins, input logic z, input logic st);
    int         cls, sub;
    logic [7:0] op;
    bit         run, serr, e_acc, e_regf, e_dmem;
    pmem_data = ins; flag_z_in = z; start = st;
    #1;
    cls = int'(ins[19:18]); sub = int'(ins[17:16]); op = ins[7:0];
    run    = (m_state == M_RUN);
    serr   = CHK && run && ((cls == 2 && sub == 3 && m_sp == 4) ||
                            (cls == 3 && sub == 0 && m_sp == 0));
    e_acc  = run && !serr && cls == 0;
    e_regf = run && !serr && cls == 1 && sub == 0;
    e_dmem = run && !serr && cls == 1 && (sub == 1 || sub == 2);
    chk("pmem_addr", pmem_addr, m_pc);
    chk("en_acc", en_acc, e_acc);
    chk("en_reg_f", en_reg_f, e_regf);
    chk("en_d_mem", en_d_mem, e_dmem);
    chk("imm", imm, op);
    chk("d_mem_addr", d_mem_addr, op);
    chk("alu_op", alu_op, ins[15:12]);
    chk("reg_f_sel", reg_f_sel, ins[11:8]);
    if (cls == 0) chk("in_b_sel", in_b_sel, (sub == 3) ? 2 : sub);
    if ((cls == 0 && sub == 3) || (cls == 1 && (sub == 1 || sub == 2)))
      chk("d_mem_addr_mode", d_mem_addr_mode, (cls == 1 && sub == 1) ? 0 : 1);

    if (m_state == M_RUN) begin
      if (serr) m_state = M_FAULT;
      else if (cls == 3 && sub == 1) m_state = M_HALT;
      else if (cls == 2 && sub == 3) begin
        m_stk[m_sp % 4] = 8'((m_pc + 1) % 256);
        m_sp = CHK ? m_sp + 1 : (m_sp + 1) % 4;
        m_depth++;
        m_pc = op;
      end else if (cls == 3 && sub == 0) begin
        m_sp = CHK ? m_sp - 1 : (m_sp + 3) % 4;
        m_pc = m_stk[m_sp % 4];
        m_depth--;
      end else if (cls == 2 && (sub == 0 || (sub == 1 && z) || (sub == 2 && !z)))
        m_pc = op;
      else m_pc = (m_pc + 1) % 256;
    end else if (m_state == M_HALT && st) begin
      m_pc = (m_pc + 1) % 256;
      m_state = M_RUN;
    end

    @(posedge clk); #1;
    start = 1'b0;
    chk("pc_next", pmem_addr, m_pc);
    chk("halted", halted, m_state == M_HALT);
    chk("fault", fault, m_state == M_FAULT);
  endtask

  // Reset asserted between edges must take effect without a clock.
  task automatic midcycle_reset();
    pmem_data = mk(0, 0, 1, 0, 8'h11);
    #3;
    pc_rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_pc", pmem_addr, 0);
    chk("rst_en_acc", en_acc, 0);
    chk("rst_halted", halted, 0);
    chk("rst_fault", fault, 0);
    @(posedge clk); #1;
    pc_rst_n = 1'b1;
  endtask

  initial begin
    int cls, sub;
    model_reset();
    pmem_data = mk(0, 0, 3, 0, 8'h2A);
    #1 pc_rst_n = 1'b0;
    #2;
    chk("reset_pc", pmem_addr, 0);
    chk("reset_en_acc", en_acc, 0);
    chk("reset_halted", halted, 0);
    chk("reset_fault", fault, 0);
    @(posedge clk); #1;
    pc_rst_n = 1'b1;

    step(mk(0, 0, 3, 0, 8'h2A), 1'b0, 1'b0);
    chk("alu_imm_pc", pmem_addr, 1);
    step(mk(2, 1, 0, 0, 8'h10), 1'b1, 1'b0);
    step(mk(2, 1, 0, 0, 8'h10), 1'b0, 1'b0);
    step(mk(2, 2, 0, 0, 8'h10), 1'b0, 1'b0);
    step(mk(2, 2, 0, 0, 8'h30), 1'b1, 1'b0);
    step(mk(0, 1, 5, 7, 8'h03), 1'b0, 1'b0);
    step(mk(0, 3, 2, 1, 8'h44), 1'b0, 1'b0);
    step(mk(1, 0, 0, 9, 8'h00), 1'b0, 1'b0);
    step(mk(1, 1, 0, 0, 8'h80), 1'b0, 1'b0);
    step(mk(1, 2, 0, 2, 8'h81), 1'b0, 1'b0);
    step(mk(2, 0, 0, 0, 8'h05), 1'b0, 1'b0);
    step(mk(2, 3, 0, 0, 8'h40), 1'b0, 1'b0);
    chk("call_target", pmem_addr, 8'h40);
    step(mk(3, 0, 0, 0, 8'h00), 1'b0, 1'b0);
    chk("ret_addr", pmem_addr, 8'h06);

    for (int i = 0; i < 4; i++) step(mk(2, 3, 0, 0, 8'h50 + i), 1'b0, 1'b0);
`ifdef CPU_CTRL_STACK_CHK_EN
    step(mk(2, 3, 0, 0, 8'h54), 1'b0, 1'b0);
    chk("ovf_fault", fault, 1);
    chk("ovf_pc_frozen", pmem_addr, 8'h53);
    step(mk(0, 0, 1, 0, 8'h01), 1'b0, 1'b1);
    step(mk(1, 1, 0, 0, 8'h02), 1'b0, 1'b0);
`else
    step(mk(2, 3, 0, 0, 8'h54), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(mk(3, 0, 0, 0, 8'h00), 1'b0, 1'b0);
    chk("ovf_ret5", pmem_addr, 8'h54);
`endif
    midcycle_reset();

`ifdef CPU_CTRL_STACK_CHK_EN
    step(mk(3, 0, 0, 0, 8'h00), 1'b0, 1'b0);
    chk("udf_fault", fault, 1);
    midcycle_reset();
`endif

    step(mk(2, 0, 0, 0, 8'h00), 1'b0, 1'b0);
    step(mk(2, 0, 0, 0, 8'h20), 1'b0, 1'b0);
    step(mk(3, 1, 0, 0, 8'h00), 1'b0, 1'b0);
    chk("halt_pc", pmem_addr, 8'h20);
    for (int i = 0; i < 10; i++)
      step(mk($urandom_range(0, 1), $urandom_range(0, 2), $urandom_range(0, 15),
              $urandom_range(0, 15), $urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
    step(mk(0, 0, 1, 0, 8'h00), 1'b0, 1'b1);
    chk("resume_pc", pmem_addr, 8'h21);
    step(mk(0, 0, 1, 0, 8'h00), 1'b0, 1'b1);
    step(mk(2, 0, 0, 0, 8'hFF), 1'b0, 1'b0);
    step(mk(3, 2, 0, 0, 8'h00), 1'b0, 1'b0);
    chk("pc_wrap", pmem_addr, 8'h00);
    step(mk(3, 3, 0, 0, 8'h00), 1'b0, 1'b0);
    step(mk(1, 3, 0, 0, 8'h00), 1'b0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      cls = $urandom_range(0, 3);
      sub = $urandom_range(0, 3);
      if ((cls == 2 && sub == 3 && m_depth >= 4) || (cls == 3 && sub == 0 && m_depth == 0)) begin
        cls = 3; sub = 2;
      end
      step(mk(cls, sub, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 255)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
    end

    midcycle_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
